// File: rtl/ltl_report_collector_if.sv
// rtl/ltl_report_collector_if.sv - result stream interface of the LTL report collector
//
// Purpose: carries the head FIFO entry of the report collector toward the
// monitor's result interface using a valid/ready handshake.
// Ports (signals):
//   out_valid     - head entry available (driven by the collector)
//   out_ready     - consumer accepts the head entry (driven by the consumer)
//   out_report    - rising-report mask of the head entry
//   out_timestamp - symbol index of the head entry
// Modports: master = collector side, slave = consumer side.

interface ltl_report_collector_if #(
  parameter int NUM_REPORTS = 4,
  parameter int TS_WIDTH    = 16
);
  logic                   out_valid;
  logic                   out_ready;
  logic [NUM_REPORTS-1:0] out_report;
  logic [TS_WIDTH-1:0]    out_timestamp;

  modport master (
    output out_valid,
    output out_report,
    output out_timestamp,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_report,
    input  out_timestamp,
    output out_ready
  );
endinterface

// File: rtl/ltl_report_collector.sv
// rtl/ltl_report_collector.sv - rising-edge report collector with timestamped FWFT FIFO
//
// Purpose: watches the report lines of one LTL automaton cluster, turns newly
// asserted report bits into {mask, symbol index} events and queues them in a
// first-word-fall-through FIFO; events arriving while the FIFO is full are
// dropped and counted.
// Ports:
//   clk            - clock, all state updates on the rising edge
//   reset          - synchronous active-high reset
//   run            - a symbol is consumed by the cluster this cycle
//   report_in      - report active-state lines, bit i = report i
//   overflow_clear - single-cycle pulse that zeroes overflow_count
//   fifo_level     - current FIFO entry count (post-edge)
//   overflow_count - saturating count of dropped events
//   out_if         - result stream (out_valid/out_ready/out_report/out_timestamp)

module ltl_report_collector #(
  parameter int NUM_REPORTS = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int TS_WIDTH    = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             run,
  input  logic [NUM_REPORTS-1:0]           report_in,
  input  logic                             overflow_clear,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic [7:0]                       overflow_count,
  ltl_report_collector_if.master           out_if
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = NUM_REPORTS + TS_WIDTH;

  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [LW-1:0]          count;
  logic [TS_WIDTH-1:0]    sym_idx;
  logic [NUM_REPORTS-1:0] prev_report;

  logic [NUM_REPORTS-1:0] rise;
  logic                   push;
  logic                   pop;
  logic                   accept;
  logic                   drop;
  logic                   valid;
  logic [EW-1:0]          head;

  assign rise   = report_in & ~prev_report;
  assign push   = run && (rise != '0);
  assign valid  = (count != '0);
  assign pop    = valid && out_if.out_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign accept = push && ((count < LW'(FIFO_DEPTH)) || pop);
  assign drop   = push && !accept;

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      sym_idx     <= '0;
      prev_report <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
      // prev_report follows report_in even on a drop, so a lost edge is never replayed.
      if (run) begin
        sym_idx     <= sym_idx + TS_WIDTH'(1);
        prev_report <= report_in;
      end
    end
  end

  // Storage needs no reset: entries are only visible while counted as valid.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {rise, sym_idx};
  end

  always_ff @(posedge clk) begin
    if (reset || overflow_clear) begin
      overflow_count <= '0;
    end else if (drop && (overflow_count != 8'hFF)) begin
      overflow_count <= overflow_count + 8'd1;
    end
  end

  assign head                 = mem[rd_ptr];
  assign out_if.out_valid     = valid;
  assign out_if.out_report    = valid ? head[EW-1:TS_WIDTH] : '0;
  assign out_if.out_timestamp = valid ? head[TS_WIDTH-1:0] : '0;
  assign fifo_level           = count;
endmodule

// File: tb/tb_ltl_report_collector.sv
// tb/tb_ltl_report_collector.sv - scoreboard bench for ltl_report_collector

module tb_ltl_report_collector;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  int         tests = 0;
  int         fails = 0;

  // Main instance: 4 reports, depth 8, 16-bit timestamps.
  logic       run0 = 1'b0;
  logic [3:0] rep0 = '0;
  logic       clr0 = 1'b0;
  logic [3:0] lvl0;
  logic [7:0] ovf0;
  ltl_report_collector_if #(.NUM_REPORTS(4), .TS_WIDTH(16)) if0 ();

  ltl_report_collector #(.NUM_REPORTS(4), .FIFO_DEPTH(8), .TS_WIDTH(16)) u0 (
    .clk(clk), .reset(reset), .run(run0), .report_in(rep0),
    .overflow_clear(clr0), .fifo_level(lvl0), .overflow_count(ovf0), .out_if(if0)
  );

  // Narrow-timestamp instance for wrap and saturation.
  logic       run1 = 1'b0;
  logic [3:0] rep1 = '0;
  logic       clr1 = 1'b0;
  logic [3:0] lvl1;
  logic [7:0] ovf1;
  ltl_report_collector_if #(.NUM_REPORTS(4), .TS_WIDTH(4)) if1 ();

  ltl_report_collector #(.NUM_REPORTS(4), .FIFO_DEPTH(8), .TS_WIDTH(4)) u1 (
    .clk(clk), .reset(reset), .run(run1), .report_in(rep1),
    .overflow_clear(clr1), .fifo_level(lvl1), .overflow_count(ovf1), .out_if(if1)
  );

  logic [19:0] q0 [$];
  logic [7:0]  q1 [$];
  logic [19:0] exp0;
  logic [7:0]  exp1;

  initial begin
    if0.out_ready = 1'b0;
    if1.out_ready = 1'b0;
  end

  // Monitors: whenever a transfer is presented, compare head against the scoreboard.
  always @(negedge clk) begin
    if (if0.out_valid && if0.out_ready) begin
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL mon0_unexpected: got %h_%h required no entry", if0.out_report, if0.out_timestamp);
      end else begin
        exp0 = q0.pop_front();
        if ({if0.out_report, if0.out_timestamp} !== exp0) begin
          fails++;
          $display("FAIL mon0_entry: got %h_%h required %h_%h",
                   if0.out_report, if0.out_timestamp, exp0[19:16], exp0[15:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (if1.out_valid && if1.out_ready) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL mon1_unexpected: got %h_%h required no entry", if1.out_report, if1.out_timestamp);
      end else begin
        exp1 = q1.pop_front();
        if ({if1.out_report, if1.out_timestamp} !== exp1) begin
          fails++;
          $display("FAIL mon1_entry: got %h_%h required %h_%h",
                   if1.out_report, if1.out_timestamp, exp1[7:4], exp1[3:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_valid"}, 32'(if0.out_valid), 32'd0);
    check({tag, "_report"}, 32'(if0.out_report), 32'd0);
    check({tag, "_ts"}, 32'(if0.out_timestamp), 32'd0);
    check({tag, "_level"}, 32'(lvl0), 32'd0);
    check({tag, "_ovf"}, 32'(ovf0), 32'd0);
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    check_reset0("rst");

    // Single edge: sym 0..2 idle, rise at sym 3, held high afterwards.
    run0 = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("single_pre_valid", 32'(if0.out_valid), 32'd0);
    rep0 = 4'b0001;
    q0.push_back({4'b0001, 16'd3});
    step();
    check("single_latency_valid", 32'(if0.out_valid), 32'd1);
    for (int i = 0; i < 4; i++) step();
    check("single_held_level", 32'(lvl0), 32'd1);
    check("single_stable_ts", 32'(if0.out_timestamp), 32'd3);
    if0.out_ready = 1'b1;
    step();
    if0.out_ready = 1'b0;
    check("single_drained", 32'(lvl0), 32'd0);

    // Multi-bit and gating: sym is 9 here; clear prev, then change during run=0.
    rep0 = 4'b0000;
    step();
    run0 = 1'b0;
    rep0 = 4'b1010;
    step();
    step();
    check("gate_no_event", 32'(lvl0), 32'd0);
    run0 = 1'b1;
    q0.push_back({4'b1010, 16'd10});
    step();
    run0 = 1'b0;
    check("gate_level", 32'(lvl0), 32'd1);
    if0.out_ready = 1'b1;
    step();
    if0.out_ready = 1'b0;

    // Overflow: sym 11 -> 12 after clearing prev; 10 events at 12,14,..,30.
    run0 = 1'b1;
    rep0 = 4'b0000;
    step();
    for (int i = 0; i < 10; i++) begin
      rep0 = 4'b0001;
      if (i < 8) q0.push_back({4'b0001, 16'(12 + 2 * i)});
      step();
      rep0 = 4'b0000;
      step();
    end
    check("ovf_level", 32'(lvl0), 32'd8);
    check("ovf_count", 32'(ovf0), 32'd2);

    // Full plus simultaneous push/pop: event at sym 32 while head pops.
    rep0 = 4'b0001;
    if0.out_ready = 1'b1;
    q0.push_back({4'b0001, 16'd32});
    step();
    run0 = 1'b0;
    if0.out_ready = 1'b0;
    check("full_pp_level", 32'(lvl0), 32'd8);
    check("full_pp_ovf", 32'(ovf0), 32'd2);
    if0.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    if0.out_ready = 1'b0;
    check("drain_level", 32'(lvl0), 32'd0);
    clr0 = 1'b1;
    step();
    clr0 = 1'b0;
    check("ovf_clear", 32'(ovf0), 32'd0);

    // Reset mid-stream: three entries queued, then discarded.
    run0 = 1'b1;
    rep0 = 4'b0000;
    step();
    rep0 = 4'b0010; step(); rep0 = 4'b0000; step();
    rep0 = 4'b0100; step(); rep0 = 4'b0000; step();
    rep0 = 4'b1000; step();
    check("mid_level", 32'(lvl0), 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset0("mid_rst");
    rep0 = 4'b0011;
    q0.push_back({4'b0011, 16'd0});
    if0.out_ready = 1'b1;
    step();
    run0 = 1'b0;
    step();
    if0.out_ready = 1'b0;
    check("mid_after_level", 32'(lvl0), 32'd0);

    // Timestamp wrap on the 4-bit instance: 17th run cycle sees ts 0.
    run1 = 1'b1;
    for (int i = 0; i < 16; i++) step();
    rep1 = 4'b0001;
    q1.push_back({4'b0001, 4'd0});
    step();
    rep1 = 4'b0000;
    if1.out_ready = 1'b1;
    step();
    if1.out_ready = 1'b0;
    check("wrap_drained", 32'(lvl1), 32'd0);

    // Saturation: 8 accepted then 300 dropped.
    for (int i = 0; i < 308; i++) begin
      rep1 = 4'b0001;
      step();
      rep1 = 4'b0000;
      step();
    end
    check("sat_level", 32'(lvl1), 32'd8);
    check("sat_count", 32'(ovf1), 32'd255);
    rep1 = 4'b0001;
    clr1 = 1'b1;
    step();
    clr1 = 1'b0;
    check("clear_priority", 32'(ovf1), 32'd0);
    rep1 = 4'b0000;
    step();
    rep1 = 4'b0001;
    step();
    check("count_after_clear", 32'(ovf1), 32'd1);
    run1 = 1'b0;

    check("q0_empty", 32'(q0.size()), 32'd0);
    check("q1_empty", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
